// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with a checkpointable head pointer.
// Optional same-cycle retire-to-dispatch bypass when empty: define PHYS_REG_FREE_LIST_BYPASS_EN.
module phys_reg_free_list #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int TAG_W = $clog2(NUM_PHYS_REGS),
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  output logic             DUT_error,
  input  logic             dispatch_free_req,
  output logic             dispatch_free_valid,
  output logic [TAG_W-1:0] dispatch_free_phys_reg_tag,
  input  logic             retire_free_valid,
  input  logic [TAG_W-1:0] retire_free_phys_reg_tag,
  output logic [PTR_W-1:0] checkpoint_head_ptr,
  input  logic             revert_valid,
  input  logic [PTR_W-1:0] revert_head_ptr,
  output logic [PTR_W-1:0] free_count
);

  localparam int IDX_W = PTR_W - 1;

  logic [TAG_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W-1:0] head_next, tail_next, revert_span;
  logic             empty, full, tag_ok;
  logic             deq, enq, bypass_take;
  logic             next_DUT_error;

  assign empty  = (head == tail);
  assign full   = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
  assign tag_ok = (retire_free_phys_reg_tag != '0);

  assign free_count          = tail - head;
  assign checkpoint_head_ptr = head;

`ifdef PHYS_REG_FREE_LIST_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit  = empty & retire_free_valid & tag_ok;
  // A revert cancels the request, so the returning tag falls back to a normal enqueue.
  assign bypass_take = bypass_hit & dispatch_free_req & ~revert_valid;
  assign dispatch_free_valid        = ~empty | bypass_hit;
  assign dispatch_free_phys_reg_tag = bypass_hit ? retire_free_phys_reg_tag
                                                 : entries[head[IDX_W-1:0]];
`else
  assign bypass_take                = 1'b0;
  assign dispatch_free_valid        = ~empty;
  assign dispatch_free_phys_reg_tag = entries[head[IDX_W-1:0]];
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    deq            = 1'b0;
    enq            = 1'b0;
    next_DUT_error = 1'b0;

    deq = dispatch_free_req & ~empty & ~revert_valid;
    enq = retire_free_valid & tag_ok & ~(full & ~deq) & ~bypass_take;

    tail_next   = tail + {{(PTR_W-1){1'b0}}, enq};
    head_next   = revert_valid ? revert_head_ptr : head + {{(PTR_W-1){1'b0}}, deq};
    revert_span = tail_next - revert_head_ptr;

    if (dispatch_free_req & ~dispatch_free_valid)          next_DUT_error = 1'b1;
    if (retire_free_valid & ~tag_ok)                       next_DUT_error = 1'b1;
    if (retire_free_valid & full & ~deq)                   next_DUT_error = 1'b1;
    if (revert_valid && (revert_span > PTR_W'(DEPTH)))     next_DUT_error = 1'b1;
  end

  // NOTE: the tag array is reset on purpose; its contents are the initial free tags, not don't-cares.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= TAG_W'(NUM_ARCH_REGS + i);
      head      <= '0;
      tail      <= PTR_W'(DEPTH);
      DUT_error <= 1'b0;
    end else begin
      if (enq) entries[tail[IDX_W-1:0]] <= retire_free_phys_reg_tag;
      head      <= head_next;
      tail      <= tail_next;
      DUT_error <= next_DUT_error;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: vector table from the drained state plus hand sequences.
module tb_phys_reg_free_list;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       DUT_error;
  logic       dispatch_free_req;
  logic       dispatch_free_valid;
  logic [5:0] dispatch_free_phys_reg_tag;
  logic       retire_free_valid;
  logic [5:0] retire_free_phys_reg_tag;
  logic [5:0] checkpoint_head_ptr;
  logic       revert_valid;
  logic [5:0] revert_head_ptr;
  logic [5:0] free_count;

  int checks = 0;
  int errors = 0;

  phys_reg_free_list dut (
    .CLK                        (CLK),
    .nRST                       (nRST),
    .DUT_error                  (DUT_error),
    .dispatch_free_req          (dispatch_free_req),
    .dispatch_free_valid        (dispatch_free_valid),
    .dispatch_free_phys_reg_tag (dispatch_free_phys_reg_tag),
    .retire_free_valid          (retire_free_valid),
    .retire_free_phys_reg_tag   (retire_free_phys_reg_tag),
    .checkpoint_head_ptr        (checkpoint_head_ptr),
    .revert_valid               (revert_valid),
    .revert_head_ptr            (revert_head_ptr),
    .free_count                 (free_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       req;
    logic       rv;
    logic [5:0] rtag;
    logic       rev;
    logic [5:0] rptr;
    logic       e_valid;
    logic       chk_tag;
    logic [5:0] e_tag;
    logic [5:0] e_cnt;
    logic [5:0] e_ckpt;
    logic       e_err;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dispatch_free_req        = 1'b0;
    retire_free_valid        = 1'b0;
    retire_free_phys_reg_tag = '0;
    revert_valid             = 1'b0;
    revert_head_ptr          = '0;
  endtask

  // Drive one cycle of inputs, clock, then sample 1ns after the edge with inputs idle.
  task automatic step(input logic req, input logic rv, input logic [5:0] rtag,
                      input logic rev, input logic [5:0] rptr);
    dispatch_free_req        = req;
    retire_free_valid        = rv;
    retire_free_phys_reg_tag = rtag;
    revert_valid             = rev;
    revert_head_ptr          = rptr;
    @(posedge CLK);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    step(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    nRST = 1'b1;
  endtask

  task automatic drain_all();
    for (int k = 0; k < 32; k++) begin
      check("drain_tag", dispatch_free_phys_reg_tag, 32 + k);
      check("drain_cnt", free_count, 32 - k);
      step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    end
    check("drain_valid", dispatch_free_valid, 0);
    check("drain_cnt_end", free_count, 0);
    check("drain_err", DUT_error, 0);
  endtask

  function automatic vec_t mk(logic req, logic rv, logic [5:0] rtag, logic rev, logic [5:0] rptr,
                              logic e_valid, logic chk_tag, logic [5:0] e_tag,
                              logic [5:0] e_cnt, logic [5:0] e_ckpt, logic e_err);
    vec_t v;
    v.req = req; v.rv = rv; v.rtag = rtag; v.rev = rev; v.rptr = rptr;
    v.e_valid = e_valid; v.chk_tag = chk_tag; v.e_tag = e_tag;
    v.e_cnt = e_cnt; v.e_ckpt = e_ckpt; v.e_err = e_err;
    return v;
  endfunction

  initial begin
    // Vectors start from the drained list: head = tail = 32 (wrap bit set, index 0).
    vecs[0] = mk(1, 0, 0,  0, 0, 0, 0, 0,  0, 32, 1);  // request while empty
    vecs[1] = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 32, 0);  // error clears
    vecs[2] = mk(0, 1, 40, 0, 0, 1, 1, 40, 1, 32, 0);  // tail wraps to index 0
    vecs[3] = mk(0, 1, 35, 0, 0, 1, 1, 40, 2, 32, 0);
    vecs[4] = mk(1, 0, 0,  0, 0, 1, 1, 35, 1, 33, 0);
    vecs[5] = mk(1, 0, 0,  0, 0, 0, 0, 0,  0, 34, 0);
    vecs[6] = mk(0, 1, 0,  0, 0, 0, 0, 0,  0, 34, 1);  // tag 0 is illegal
    vecs[7] = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 34, 0);
`ifdef PHYS_REG_FREE_LIST_BYPASS_EN
    vecs[8] = mk(1, 1, 10, 0, 0, 0, 0, 0,  0, 34, 0);  // passes straight through
    vecs[9] = mk(1, 0, 0,  0, 0, 0, 0, 0,  0, 34, 1);
`else
    vecs[8] = mk(1, 1, 10, 0, 0, 1, 1, 10, 1, 34, 1);  // request errors, tag enqueues
    vecs[9] = mk(1, 0, 0,  0, 0, 0, 0, 0,  0, 35, 0);
`endif

    nRST = 1'b1;
    idle_inputs();
    #1;
    do_reset();

    check("rst_valid", dispatch_free_valid, 1);
    check("rst_tag",   dispatch_free_phys_reg_tag, 32);
    check("rst_cnt",   free_count, 32);
    check("rst_ckpt",  checkpoint_head_ptr, 0);
    check("rst_err",   DUT_error, 0);

    drain_all();

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].req, vecs[i].rv, vecs[i].rtag, vecs[i].rev, vecs[i].rptr);
      check($sformatf("vec%0d_valid", i), dispatch_free_valid, vecs[i].e_valid);
      if (vecs[i].chk_tag)
        check($sformatf("vec%0d_tag", i), dispatch_free_phys_reg_tag, vecs[i].e_tag);
      check($sformatf("vec%0d_cnt", i),  free_count, vecs[i].e_cnt);
      check($sformatf("vec%0d_ckpt", i), checkpoint_head_ptr, vecs[i].e_ckpt);
      check($sformatf("vec%0d_err", i),  DUT_error, vecs[i].e_err);
    end

    // Full list: a lone retire is dropped; retire with dispatch is legal.
    do_reset();
    step(1'b0, 1'b1, 6'd50, 1'b0, 6'd0);
    check("full_drop_err", DUT_error, 1);
    check("full_drop_cnt", free_count, 32);
    check("full_drop_tag", dispatch_free_phys_reg_tag, 32);
    step(1'b1, 1'b1, 6'd50, 1'b0, 6'd0);
    check("full_swap_err", DUT_error, 0);
    check("full_swap_cnt", free_count, 32);
    check("full_swap_tag", dispatch_free_phys_reg_tag, 33);

    // Checkpoint at head 5, dispatch 3, revert with a same-cycle request and retire.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    check("ckpt_ptr", checkpoint_head_ptr, 5);
    check("ckpt_tag", dispatch_free_phys_reg_tag, 37);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    check("pre_rev_cnt", free_count, 24);
    check("pre_rev_tag", dispatch_free_phys_reg_tag, 40);
    step(1'b1, 1'b0, 6'd0, 1'b1, 6'd5);
    check("rev_ptr", checkpoint_head_ptr, 5);
    check("rev_tag", dispatch_free_phys_reg_tag, 37);
    check("rev_cnt", free_count, 27);
    check("rev_err", DUT_error, 0);
    step(1'b0, 1'b1, 6'd12, 1'b1, 6'd5);
    check("rev_enq_cnt", free_count, 28);
    check("rev_enq_err", DUT_error, 0);
    step(1'b0, 1'b0, 6'd0, 1'b1, 6'd40);
    check("rev_bad_err", DUT_error, 1);

    // Empty list: dispatch request and retire of tag 44 in the same cycle.
    do_reset();
    drain_all();
    dispatch_free_req        = 1'b1;
    retire_free_valid        = 1'b1;
    retire_free_phys_reg_tag = 6'd44;
    #2;
`ifdef PHYS_REG_FREE_LIST_BYPASS_EN
    check("byp_valid", dispatch_free_valid, 1);
    check("byp_tag",   dispatch_free_phys_reg_tag, 44);
    @(posedge CLK);
    #1;
    idle_inputs();
    check("byp_cnt", free_count, 0);
    check("byp_err", DUT_error, 0);
    check("byp_valid_after", dispatch_free_valid, 0);
`else
    check("nobyp_valid", dispatch_free_valid, 0);
    @(posedge CLK);
    #1;
    idle_inputs();
    check("nobyp_valid_next", dispatch_free_valid, 1);
    check("nobyp_tag_next",   dispatch_free_phys_reg_tag, 44);
    check("nobyp_cnt",        free_count, 1);
    check("nobyp_err",        DUT_error, 1);
`endif

    // Reset mid-stream overrides all inputs.
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    check("mid_tag", dispatch_free_phys_reg_tag, 42);
    check("mid_cnt", free_count, 22);
    nRST = 1'b0;
    step(1'b1, 1'b1, 6'd7, 1'b1, 6'd3);
    nRST = 1'b1;
    check("mid_rst_cnt",   free_count, 32);
    check("mid_rst_tag",   dispatch_free_phys_reg_tag, 32);
    check("mid_rst_valid", dispatch_free_valid, 1);
    check("mid_rst_ckpt",  checkpoint_head_ptr, 0);
    check("mid_rst_err",   DUT_error, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Circular FIFO of free physical register tags feeding the dispatch unit's rename path. It supplies the destination tag that dispatch clears in the ready table. Retire returns freed tags to it. A branch-checkpointed head pointer supports single-cycle recovery on mispredict.

## Interface
Parameters:
- NUM_PHYS_REGS, 64, total physical registers.
- NUM_ARCH_REGS, 32, architectural registers.
- Derived values:
  - DEPTH = NUM_PHYS_REGS-NUM_ARCH_REGS, which must be a power of 2.
  - TAG_W = $clog2(NUM_PHYS_REGS).
  - PTR_W = $clog2(DEPTH)+1, including a wrap bit.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- DUT_error  out  1  registered error flag.
- dispatch_free_req  in  1  dispatch consumes one tag this cycle.
- dispatch_free_valid  out  1  a tag is available.
- dispatch_free_phys_reg_tag  out  TAG_W  tag offered to dispatch.
- retire_free_valid  in  1  retire returns one tag.
- retire_free_phys_reg_tag  in  TAG_W  tag returned.
- checkpoint_head_ptr  out  PTR_W  current head pointer, snapshotted by the branch checkpoint logic.
- revert_valid  in  1  restore head on mispredict.
- revert_head_ptr  in  PTR_W  head pointer to restore.
- free_count  out  PTR_W  number of free tags held.

## Operation
State:
- entries[DEPTH] of TAG_W.
- head and tail pointers of PTR_W.
- DUT_error.

Derived conditions:
- empty = (head == tail).
- full = index bits equal and wrap bits differ.
- free_count = tail - head (mod 2^PTR_W).

Reset:
- entries[i] = NUM_ARCH_REGS+i.
- head = 0.
- tail = DEPTH (wrap bit set, so the list starts full).
- DUT_error = 0.

Dequeue:
- Occurs when dispatch_free_req & dispatch_free_valid & ~revert_valid.
- head increments by 1.
- dispatch_free_phys_reg_tag = entries[head index].

Requesting when empty:
- A request while dispatch_free_valid=0 sets DUT_error and does not dequeue.
- Upstream is responsible for stalling in this case.

Enqueue:
- Occurs when retire_free_valid.
- entries[tail index] <= tag, and tail increments by 1.
- Dropped, with error, if full and no same-cycle dequeue.
- Dropped, with error, if tag == 0.

Revert:
- head <= revert_head_ptr.
- A same-cycle dispatch request is ignored.
- A same-cycle enqueue still completes.
- Error if (tail_next - revert_head_ptr) > DEPTH.

Simultaneous dequeue and enqueue while full is legal: the count is unchanged.

next_DUT_error is computed each cycle and registered. It stays asserted only while its condition persists.

## Timing
- Outputs dispatch_free_valid, dispatch_free_phys_reg_tag, checkpoint_head_ptr and free_count are combinational from registered state only, with no input-to-output path, except the bypass described under Configuration.
- Effect of a dequeue is visible on the next cycle.
- An enqueued tag becomes offerable no earlier than the next cycle when non-bypassed.
- A revert takes effect on the next cycle; the restored tags are re-offered starting from revert_head_ptr.
- Reset outputs:
  - dispatch_free_valid = 1.
  - dispatch_free_phys_reg_tag = NUM_ARCH_REGS.
  - free_count = DEPTH.
  - checkpoint_head_ptr = 0.
  - DUT_error = 0.
- Reset asserted mid-operation restores full reset state at the next edge, overriding all inputs.
- Pointer wrap: the index wraps modulo DEPTH and the wrap bit toggles.

## Configuration
PHYS_REG_FREE_LIST_BYPASS_EN, when defined:
- If empty & retire_free_valid & tag != 0, then:
  - dispatch_free_valid = 1.
  - dispatch_free_phys_reg_tag = retire_free_phys_reg_tag.
- If dispatch_free_req is also high, the tag passes straight through and head/tail are unchanged.
- If dispatch_free_req is low, a normal enqueue happens.

When undefined:
- Empty always gives dispatch_free_valid = 0, and the tag returns to the list through a normal enqueue.

## Test plan
- Reset, then 32 consecutive dispatch requests:
  - Tags 32..63 are offered in order.
  - free_count decrements to 0 and valid drops after the 32nd.
  - DUT_error stays 0.
- Drain to empty, then retire tags 40, 35 and dispatch after:
  - Tag 40, then 35, is offered.
  - free_count goes 2, then 1, then 0.
  - Tail and head wrap correctly.
- At reset-full, retire tag 50 with no dispatch:
  - Enqueue is dropped and DUT_error = 1 on the next cycle.
  - Retiring tag 0 at any time also gives DUT_error = 1.
- Checkpoint at head=5, dispatch 3 tags, assert revert_valid with revert_head_ptr=5 plus a same-cycle dispatch request:
  - The next cycle offers the tag previously at index 5.
  - free_count increases by 3.
  - The dispatch request is ignored.
- With PHYS_REG_FREE_LIST_BYPASS_EN and the list empty, apply dispatch request plus retire of tag 44:
  - dispatch_free_phys_reg_tag = 44 in the same cycle.
  - free_count stays 0.
  - Without the macro, valid = 0 that cycle and 44 is offered the next cycle.
- Assert nRST low mid-stream after 10 dequeues:
  - Next cycle free_count = 32 and the offered tag = 32.
